// File: rtl/bitvec_uart_tx_pkg.sv
// Shared ASCII constants and FSM state encoding for the bit-vector UART link.
package bitvec_uart_tx_pkg;
  localparam logic [7:0] ASCII_0    = 8'h30;
  localparam logic [7:0] ASCII_SEP  = 8'h20;
  localparam logic [7:0] ASCII_TERM = 8'h2A;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_BITS = 3'd2,
    ST_SEP  = 3'd3,
    ST_TERM = 3'd4
  } state_t;
endpackage

// File: rtl/bitvec_uart_tx_if.sv
// Byte stream towards the USB-UART IN pipe; valid/ready, one byte per transfer.
interface bitvec_uart_tx_if;
  logic [7:0] uart_in_data;
  logic       uart_in_valid;
  logic       uart_in_ready;

  modport master (output uart_in_data, output uart_in_valid, input uart_in_ready);
  modport slave  (input uart_in_data, input uart_in_valid, output uart_in_ready);
endinterface

// File: rtl/bitvec_char_enc.sv
// Combinational: selects one snapshot bit and renders it as ASCII '0'/'1'.
// An index at or beyond OL renders as '0'.
module bitvec_char_enc
  import bitvec_uart_tx_pkg::*;
#(
  parameter int OL = 64,
  parameter int IW = $clog2(OL + 1)
) (
  input  logic [OL-1:0] i_snap,
  input  logic [IW-1:0] i_idx,
  output logic [7:0]    o_char
);
  logic w_bit;

  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < OL; i++) begin
      if (i_idx == IW'(i)) w_bit = i_snap[i];
    end
  end

  assign o_char = ASCII_0 | {7'd0, w_bit};
endmodule

// File: rtl/bitvec_uart_tx.sv
// Streams a snapshot of vec_in as "0101... 0110*" bytes; first byte valid 2 cycles after enable.
// Registered valid/data held while ready is low. Macro CHANGE_ONLY_EN: only send when vec_in changed.
module bitvec_uart_tx
  import bitvec_uart_tx_pkg::*;
#(
  parameter int         OL   = 64,
  parameter int         COLS = 8,
  parameter logic [7:0] SEP  = ASCII_SEP,
  parameter logic [7:0] TERM = ASCII_TERM
) (
  input  logic                clk_48mhz,
  input  logic                reset,
  input  logic                enable,
  input  logic [OL-1:0]       vec_in,
  bitvec_uart_tx_if.master    uart,
  output logic                busy,
  output logic                frame_done
);
  localparam int IW = $clog2(OL + 1);
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(OL - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  state_t        r_state, w_state_nxt;
  logic [OL-1:0] r_snap, w_snap_nxt;
  logic [IW-1:0] r_bit_idx, w_bit_idx_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [7:0]    r_data, w_data_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_frame_done, w_frame_done_nxt;

  logic          w_xfer;
  logic          w_start;
  logic [OL-1:0] w_enc_snap;
  logic [IW-1:0] w_enc_idx;
  logic [7:0]    w_enc_char;

  assign w_xfer = r_valid && uart.uart_in_ready;

`ifdef CHANGE_ONLY_EN
  logic [OL-1:0] r_last_sent;
  logic          r_first_sent;

  assign w_start = enable && (!r_first_sent || (vec_in != r_last_sent));

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      r_last_sent  <= '0;
      r_first_sent <= 1'b0;
    end else if (r_state == ST_TERM && w_xfer) begin
      r_last_sent  <= r_snap;
      r_first_sent <= 1'b1;
    end
  end
`else
  assign w_start = enable;
`endif

  // Encoder looks at the bit that becomes current on the next edge, so the byte is registered.
  assign w_enc_snap = (r_state == ST_LOAD) ? vec_in : r_snap;
  assign w_enc_idx  = (r_state == ST_LOAD) ? '0 :
                      (r_state == ST_BITS) ? r_bit_idx + IW'(1) : r_bit_idx;

  bitvec_char_enc #(.OL(OL), .IW(IW)) u_char_enc (
    .i_snap (w_enc_snap),
    .i_idx  (w_enc_idx),
    .o_char (w_enc_char)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_snap_nxt       = r_snap;
    w_bit_idx_nxt    = r_bit_idx;
    w_col_nxt        = r_col;
    w_data_nxt       = r_data;
    w_valid_nxt      = r_valid;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_snap_nxt    = vec_in;
        w_bit_idx_nxt = '0;
        w_col_nxt     = '0;
        w_data_nxt    = w_enc_char;
        w_valid_nxt   = 1'b1;
        w_state_nxt   = ST_BITS;
      end
      ST_BITS: begin
        if (w_xfer) begin
          w_bit_idx_nxt = r_bit_idx + IW'(1);
          if (r_bit_idx == IDX_LAST) begin
            w_data_nxt  = TERM;
            w_state_nxt = ST_TERM;
          end else if (r_col == COL_LAST) begin
            w_data_nxt  = SEP;
            w_col_nxt   = '0;
            w_state_nxt = ST_SEP;
          end else begin
            w_data_nxt  = w_enc_char;
            w_col_nxt   = r_col + CW'(1);
          end
        end
      end
      ST_SEP: begin
        if (w_xfer) begin
          w_data_nxt  = w_enc_char;
          w_state_nxt = ST_BITS;
        end
      end
      ST_TERM: begin
        if (w_xfer) begin
          w_frame_done_nxt = 1'b1;
          w_valid_nxt      = 1'b0;
          w_state_nxt      = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_snap       <= '0;
      r_bit_idx    <= '0;
      r_col        <= '0;
      r_data       <= '0;
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_snap       <= w_snap_nxt;
      r_bit_idx    <= w_bit_idx_nxt;
      r_col        <= w_col_nxt;
      r_data       <= w_data_nxt;
      r_valid      <= w_valid_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign uart.uart_in_data  = r_data;
  assign uart.uart_in_valid = r_valid;
  assign busy               = (r_state != ST_IDLE);
  assign frame_done         = r_frame_done;
endmodule

// File: tb/tb_bitvec_uart_tx.sv
// Directed bench for bitvec_uart_tx: 64/8 main instance plus OL=5 and OL=8 instances.
module tb_bitvec_uart_tx;
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset, enable, ready;
  logic [63:0] vec;
  logic        busy, frame_done;
  logic        enable_s, ready_s;
  logic [4:0]  vec5;
  logic [7:0]  vec8;
  logic        busy5, fd5, busy8, fd8;

  bitvec_uart_tx_if u_if ();
  bitvec_uart_tx_if u_if5 ();
  bitvec_uart_tx_if u_if8 ();
  assign u_if.uart_in_ready  = ready;
  assign u_if5.uart_in_ready = ready_s;
  assign u_if8.uart_in_ready = ready_s;

  bitvec_uart_tx #(.OL(64), .COLS(8), .SEP(8'h20), .TERM(8'h2A)) dut (
    .clk_48mhz(clk), .reset(reset), .enable(enable), .vec_in(vec),
    .uart(u_if), .busy(busy), .frame_done(frame_done));
  bitvec_uart_tx #(.OL(5), .COLS(8), .SEP(8'h20), .TERM(8'h2A)) dut5 (
    .clk_48mhz(clk), .reset(reset), .enable(enable_s), .vec_in(vec5),
    .uart(u_if5), .busy(busy5), .frame_done(fd5));
  bitvec_uart_tx #(.OL(8), .COLS(8), .SEP(8'h20), .TERM(8'h2A)) dut8 (
    .clk_48mhz(clk), .reset(reset), .enable(enable_s), .vec_in(vec8),
    .uart(u_if8), .busy(busy8), .frame_done(fd8));

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  cap_q[$];
  logic [7:0]  exp_q[$];
  int          fd_cnt, fd_at, stab_err, stall_cnt;
  bit          cap_to;
  logic [63:0] load_vec;

  // Reference frame: bit 0 first, separator after every 8th bit except the last, then '*'.
  task automatic build_exp(input logic [63:0] v);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      exp_q.push_back(v[i] ? 8'h31 : 8'h30);
      if (i != 63 && (i % 8) == 7) exp_q.push_back(8'h20);
    end
    exp_q.push_back(8'h2A);
  endtask

  task automatic do_reset();
    reset = 1'b0; enable = 1'b0; ready = 1'b0; enable_s = 1'b0; ready_s = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Collects n transferred bytes from the main instance; one extra cycle catches frame_done.
  task automatic capture(input int n, input int mode, input bit vary, input int drop_at, input int budget);
    int c = 0;
    bit stalled = 1'b0;
    bit xfer;
    logic [7:0] pdata = 8'h00;
    cap_q.delete(); fd_cnt = 0; fd_at = -1; stab_err = 0; stall_cnt = 0; cap_to = 1'b0;
    while (cap_q.size() < n && !cap_to) begin
      @(negedge clk);
      if (mode == 0) ready = 1'b1;
      else ready = ((c % 20) >= 10 && (c % 20) < 15) ? 1'b0 : 1'($urandom_range(0, 1));
      if (vary) begin
        vec = {$urandom, $urandom};
        if (busy && !u_if.uart_in_valid) load_vec = vec;
      end
      if (stalled && (!u_if.uart_in_valid || u_if.uart_in_data !== pdata)) stab_err++;
      if (frame_done) begin fd_cnt++; fd_at = cap_q.size(); end
      xfer    = u_if.uart_in_valid && ready;
      stalled = u_if.uart_in_valid && !ready;
      if (stalled) stall_cnt++;
      pdata = u_if.uart_in_data;
      if (xfer) cap_q.push_back(u_if.uart_in_data);
      if (drop_at > 0 && cap_q.size() == drop_at) enable = 1'b0;
      c++;
      if (c >= budget) cap_to = 1'b1;
    end
    @(negedge clk);
    ready = 1'b0;
    if (frame_done) begin fd_cnt++; fd_at = cap_q.size(); end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; ready = 1'b0; enable_s = 1'b0; ready_s = 1'b0;
    vec = '0; vec5 = '0; vec8 = '0; load_vec = '0;
    repeat (2) @(negedge clk);
    vectors++; if (u_if.uart_in_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", u_if.uart_in_valid); end
    vectors++; if (u_if.uart_in_data !== 8'h00) begin miscompares++; $display("FAIL reset_data got=%h want=00", u_if.uart_in_data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got=%b want=0", frame_done); end
    vectors++; if ({busy5, busy8, u_if5.uart_in_valid, u_if8.uart_in_valid} !== 4'b0) begin
      miscompares++; $display("FAIL reset_small got=%b want=0000", {busy5, busy8, u_if5.uart_in_valid, u_if8.uart_in_valid});
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    vec = 64'h0000_0000_0000_0001;
    build_exp(vec);
    enable = 1'b1;
    @(negedge clk);
    vectors++; if ({busy, u_if.uart_in_valid} !== 2'b10) begin miscompares++; $display("FAIL load_cycle busy/valid got=%b want=10", {busy, u_if.uart_in_valid}); end
    @(negedge clk);
    vectors++; if (u_if.uart_in_valid !== 1'b1 || u_if.uart_in_data !== 8'h31) begin
      miscompares++; $display("FAIL first_byte valid=%b data=%h want 1/31", u_if.uart_in_valid, u_if.uart_in_data);
    end
    capture(72, 0, 1'b0, 0, 500);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL basic_len got=%0d want=72", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 72; i++) begin
      vectors++; if (cap_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL basic_byte[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
    if (cap_q.size() == 72) begin
      vectors++; if ({cap_q[0], cap_q[8], cap_q[71]} !== {8'h31, 8'h20, 8'h2A}) begin
        miscompares++; $display("FAIL basic_landmarks got=%h %h %h want=31 20 2a", cap_q[0], cap_q[8], cap_q[71]);
      end
    end
    vectors++; if (fd_cnt != 1 || fd_at != 72) begin miscompares++; $display("FAIL basic_frame_done count=%0d at=%0d want 1 at 72", fd_cnt, fd_at); end
  endtask

  task automatic test_stall();
    do_reset();
    vec = 64'h0000_0000_0000_0001;
    build_exp(vec);
    enable = 1'b1;
    capture(72, 1, 1'b0, 0, 3000);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL stall_len got=%0d want=72", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 72; i++) begin
      vectors++; if (cap_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL stall_byte[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
    vectors++; if (stab_err != 0) begin miscompares++; $display("FAIL stall_hold errors=%0d want=0", stab_err); end
    vectors++; if (stall_cnt < 5) begin miscompares++; $display("FAIL stall_coverage stalls=%0d want>=5", stall_cnt); end
    vectors++; if (fd_cnt != 1) begin miscompares++; $display("FAIL stall_frame_done count=%0d want=1", fd_cnt); end
  endtask

  task automatic test_vec_change();
    do_reset();
    vec = 64'hFFFF_0000_AAAA_5555;
    load_vec = 64'hxxxx_xxxx_xxxx_xxxx;
    enable = 1'b1;
    capture(72, 0, 1'b1, 0, 500);
    build_exp(load_vec);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL vecchg_len got=%0d want=72", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 72; i++) begin
      vectors++; if (cap_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL vecchg_byte[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_enable_drop();
    do_reset();
    vec = 64'h8000_0000_0000_00F1;
    build_exp(vec);
    enable = 1'b1;
    capture(72, 0, 1'b0, 10, 500);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL endrop_len got=%0d want=72", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 72; i++) begin
      vectors++; if (cap_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL endrop_byte[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
    ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if ({busy, u_if.uart_in_valid} !== 2'b00) begin miscompares++; $display("FAIL endrop_idle busy/valid got=%b want=00", {busy, u_if.uart_in_valid}); end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    vec = 64'h0123_4567_89AB_CDEF;
    build_exp(vec);
    enable = 1'b1;
    capture(29, 0, 1'b0, 0, 500);
    vectors++; if (u_if.uart_in_valid !== 1'b1 || u_if.uart_in_data !== exp_q[29]) begin
      miscompares++; $display("FAIL rstmid_byte30 valid=%b data=%h want 1/%h", u_if.uart_in_valid, u_if.uart_in_data, exp_q[29]);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++; if ({busy, u_if.uart_in_valid, frame_done} !== 3'b000 || u_if.uart_in_data !== 8'h00) begin
      miscompares++; $display("FAIL rstmid_cleared busy/valid/fd=%b data=%h want 000/00", {busy, u_if.uart_in_valid, frame_done}, u_if.uart_in_data);
    end
    reset = 1'b1;
    vec = 64'h0000_0000_0000_0002;
    build_exp(vec);
    capture(72, 0, 1'b0, 0, 500);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL rstmid_len got=%0d want=72", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 72; i++) begin
      vectors++; if (cap_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rstmid_byte[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
    vectors++; if (fd_cnt != 1) begin miscompares++; $display("FAIL rstmid_frame_done count=%0d want=1", fd_cnt); end
  endtask

  task automatic test_change_only();
    int busy_cycles = 0;
    do_reset();
    vec = 64'h0000_0000_0000_000F;
    build_exp(vec);
    enable = 1'b1;
    capture(72, 0, 1'b0, 0, 500);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL frame1_len got=%0d want=72", cap_q.size()); end
    for (int i = 0; i < cap_q.size() && i < 72; i++) begin
      vectors++; if (cap_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL frame1_byte[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
`ifdef CHANGE_ONLY_EN
    ready = 1'b1;
    repeat (216) begin
      @(negedge clk);
      if (busy || u_if.uart_in_valid) busy_cycles++;
    end
    vectors++; if (busy_cycles != 0) begin miscompares++; $display("FAIL chg_only_quiet busy_cycles=%0d want=0", busy_cycles); end
    vec[5] = ~vec[5];
    build_exp(vec);
    capture(72, 0, 1'b0, 0, 500);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL frame2_len got=%0d want=72", cap_q.size()); end
    if (cap_q.size() > 5) begin
      vectors++; if (cap_q[5] !== 8'h31) begin miscompares++; $display("FAIL frame2_bit5 got=%h want=31", cap_q[5]); end
    end
`else
    @(negedge clk);
    vectors++; if ({busy, u_if.uart_in_valid} !== 2'b10) begin miscompares++; $display("FAIL gap_load busy/valid got=%b want=10", {busy, u_if.uart_in_valid}); end
    @(negedge clk);
    vectors++; if (u_if.uart_in_valid !== 1'b1) begin miscompares++; $display("FAIL gap_next_valid got=%b want=1", u_if.uart_in_valid); end
    capture(72, 0, 1'b0, 0, 500);
    vectors++; if (cap_to || cap_q.size() != 72) begin miscompares++; $display("FAIL frame2_len got=%0d want=72", cap_q.size()); end
    vectors++; if (busy_cycles != 0) begin miscompares++; $display("FAIL gap_counter got=%0d want=0", busy_cycles); end
`endif
    for (int i = 0; i < cap_q.size() && i < 72; i++) begin
      vectors++; if (cap_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL frame2_byte[%0d] got=%h want=%h", i, cap_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_small();
    logic [7:0] q5[$];
    logic [7:0] q8[$];
    string s5 = "01101*";
    string s8 = "10100011*";
    int fd5_cnt = 0;
    int fd8_cnt = 0;
    do_reset();
    vec5 = 5'b10110;
    vec8 = 8'hC5;
    enable_s = 1'b1;
    ready_s = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (fd5) fd5_cnt++;
      if (fd8) fd8_cnt++;
      if (u_if5.uart_in_valid && q5.size() < 6) q5.push_back(u_if5.uart_in_data);
      if (u_if8.uart_in_valid && q8.size() < 9) q8.push_back(u_if8.uart_in_data);
      if (q5.size() > 0) enable_s = 1'b0;
    end
    vectors++; if (q5.size() != 6) begin miscompares++; $display("FAIL ol5_len got=%0d want=6", q5.size()); end
    for (int i = 0; i < q5.size() && i < 6; i++) begin
      vectors++; if (q5[i] !== 8'(s5[i])) begin miscompares++; $display("FAIL ol5_byte[%0d] got=%h want=%h", i, q5[i], 8'(s5[i])); end
    end
    vectors++; if (q8.size() != 9) begin miscompares++; $display("FAIL ol8_len got=%0d want=9", q8.size()); end
    for (int i = 0; i < q8.size() && i < 9; i++) begin
      vectors++; if (q8[i] !== 8'(s8[i])) begin miscompares++; $display("FAIL ol8_byte[%0d] got=%h want=%h", i, q8[i], 8'(s8[i])); end
    end
    vectors++; if (fd5_cnt != 1 || fd8_cnt != 1) begin miscompares++; $display("FAIL small_frame_done got=%0d/%0d want=1/1", fd5_cnt, fd8_cnt); end
    vectors++; if ({busy5, busy8} !== 2'b00) begin miscompares++; $display("FAIL small_idle got=%b want=00", {busy5, busy8}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_vec_change();
    test_enable_drop();
    test_reset_mid();
    test_change_only();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
